// File: rtl/fill_vblank.sv
// ---------------------------------------------------------------------------
// fill_vblank
//
// Vertical companion to the horizontal black-padding stage. Incoming lines
// are already H_DISP pixels wide. This block counts them per frame and crops
// any line beyond V_DISP. At end of frame it appends whole lines of the fill
// colour until the frame holds exactly V_DISP lines. While it is inserting
// lines it raises busy_o so that the upstream scaler holds off.
//
// Optional feature (macro FILL_VBLANK_COLOR_EN):
//   defined   : adds the fillColor_i port. The value is sampled at frameEnd_i
//               and held for the whole fill.
//   undefined : inserted pixels are black (24'h000000).
//
// Ports:
//   clk          in   1   pixel clock; all logic runs on the rising edge
//   rst_n        in   1   synchronous active-low reset
//   data_i       in  24   RGB888 pixel from the horizontal fill stage
//   dataValid_i  in   1   pixel valid; one high run is one line
//   frameEnd_i   in   1   one-cycle pulse; the last line of the frame is in
//   fillColor_i  in  24   fill colour (only with FILL_VBLANK_COLOR_EN)
//   data_o       out 24   registered RGB888 pixel
//   dataValid_o  out  1   registered pixel valid
//   busy_o       out  1   high while lines are being inserted
//   linesIn_o    out 12   input line count of the last completed frame
//   overflow_o   out  1   sticky; a pixel arrived while inserting
// ---------------------------------------------------------------------------
module fill_vblank #(
    parameter logic [11:0] H_DISP   = 12'd1920,
    parameter logic [11:0] V_DISP   = 12'd1080,
    parameter logic [11:0] LINE_GAP = 12'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_i,
    input  logic        dataValid_i,
    input  logic        frameEnd_i,
`ifdef FILL_VBLANK_COLOR_EN
    input  logic [23:0] fillColor_i,
`endif
    output logic [23:0] data_o,
    output logic        dataValid_o,
    output logic        busy_o,
    output logic [11:0] linesIn_o,
    output logic        overflow_o
);

    typedef enum logic [1:0] {
        PASS      = 2'd0,
        FILL_LINE = 2'd1,
        FILL_GAP  = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] line_cnt, line_cnt_nxt;
    logic [11:0] px_cnt, px_cnt_nxt;
    logic [11:0] gap_cnt, gap_cnt_nxt;
    logic [11:0] remain, remain_nxt;
    logic        valid_d, valid_d_nxt;
    logic [23:0] fill_color, fill_color_nxt;
    logic [23:0] data_nxt;
    logic        valid_o_nxt;
    logic        busy_nxt;
    logic [11:0] lines_in_nxt;
    logic        overflow_nxt;

    logic        line_end;
    logic [12:0] eff_cnt;
    logic [11:0] n_eff;
    logic [11:0] line_cnt_inc;
    logic [23:0] color_in;

`ifdef FILL_VBLANK_COLOR_EN
    assign color_in = fillColor_i;
`else
    assign color_in = 24'h000000;
`endif

    // A line ends on the cycle where dataValid_i falls.
    assign line_end     = valid_d & ~dataValid_i;
    assign line_cnt_inc = (line_cnt == 12'hFFF) ? line_cnt : line_cnt + 12'd1;

    // At frameEnd_i, a line that ends now or is still in flight counts as
    // complete. The sum is widened so that it saturates instead of wrapping.
    assign eff_cnt = {1'b0, line_cnt} + {12'd0, (line_end | dataValid_i)};
    assign n_eff   = eff_cnt[12] ? 12'hFFF : eff_cnt[11:0];

    // Next-state and next-output logic. All registered outputs are computed
    // here so that the register process below stays a plain copy.
    always_comb begin
        state_nxt      = state;
        line_cnt_nxt   = line_cnt;
        px_cnt_nxt     = px_cnt;
        gap_cnt_nxt    = gap_cnt;
        remain_nxt     = remain;
        valid_d_nxt    = 1'b0;
        fill_color_nxt = fill_color;
        data_nxt       = 24'h000000;
        valid_o_nxt    = 1'b0;
        busy_nxt       = busy_o;
        lines_in_nxt   = linesIn_o;
        overflow_nxt   = overflow_o;

        case (state)
            PASS: begin
                // Edge tracking only runs here. This keeps pixels that are
                // dropped during a fill out of the next frame's line count.
                valid_d_nxt = dataValid_i;
                if (line_end) begin
                    line_cnt_nxt = line_cnt_inc;
                end
                // Lines past V_DISP are cropped to blank output.
                if (line_cnt < V_DISP) begin
                    data_nxt    = data_i;
                    valid_o_nxt = dataValid_i;
                end
                if (frameEnd_i) begin
                    lines_in_nxt   = n_eff;
                    line_cnt_nxt   = 12'd0;
                    // The current line is already counted, so its falling
                    // edge must not be counted again next cycle.
                    valid_d_nxt    = 1'b0;
                    fill_color_nxt = color_in;
                    if (n_eff < V_DISP) begin
                        remain_nxt = V_DISP - n_eff;
                        px_cnt_nxt = 12'd0;
                        busy_nxt   = 1'b1;
                        state_nxt  = FILL_LINE;
                    end
                end
            end

            FILL_LINE: begin
                valid_o_nxt = 1'b1;
                data_nxt    = fill_color;
                px_cnt_nxt  = px_cnt + 12'd1;
                if (px_cnt == H_DISP - 12'd1) begin
                    remain_nxt = remain - 12'd1;
                    px_cnt_nxt = 12'd0;
                    if (remain == 12'd1) begin
                        // busy_o drops together with the last fill pixel,
                        // so it does not cover the DONE cycle.
                        busy_nxt  = 1'b0;
                        state_nxt = DONE;
                    end else if (LINE_GAP != 12'd0) begin
                        gap_cnt_nxt = 12'd0;
                        state_nxt   = FILL_GAP;
                    end
                end
            end

            FILL_GAP: begin
                gap_cnt_nxt = gap_cnt + 12'd1;
                if (gap_cnt == LINE_GAP - 12'd1) begin
                    px_cnt_nxt = 12'd0;
                    state_nxt  = FILL_LINE;
                end
            end

            DONE: begin
                line_cnt_nxt = 12'd0;
                busy_nxt     = 1'b0;
                state_nxt    = PASS;
            end

            default: begin
                state_nxt = PASS;
            end
        endcase

        // While inserting, pixels from upstream are dropped and flagged.
        if (state != PASS && dataValid_i) begin
            overflow_nxt = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= PASS;
            line_cnt    <= 12'd0;
            px_cnt      <= 12'd0;
            gap_cnt     <= 12'd0;
            remain      <= 12'd0;
            valid_d     <= 1'b0;
            fill_color  <= 24'h000000;
            data_o      <= 24'h000000;
            dataValid_o <= 1'b0;
            busy_o      <= 1'b0;
            linesIn_o   <= 12'd0;
            overflow_o  <= 1'b0;
        end else begin
            state       <= state_nxt;
            line_cnt    <= line_cnt_nxt;
            px_cnt      <= px_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            remain      <= remain_nxt;
            valid_d     <= valid_d_nxt;
            fill_color  <= fill_color_nxt;
            data_o      <= data_nxt;
            dataValid_o <= valid_o_nxt;
            busy_o      <= busy_nxt;
            linesIn_o   <= lines_in_nxt;
            overflow_o  <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_fill_vblank.sv
// ---------------------------------------------------------------------------
// tb_fill_vblank
//
// Self-checking bench for fill_vblank with H_DISP=8, V_DISP=4, LINE_GAP=2.
// Each frame is described at the line level: which lines pass, which are
// cropped, and how many fill lines and gaps follow. That description is
// expanded into a per-cycle expected output stream, and the stream is
// compared against what the DUT produces.
// ---------------------------------------------------------------------------
module tb_fill_vblank;

    localparam int H = 8;
    localparam int V = 4;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] data_i = '0;
    logic        dataValid_i = 1'b0;
    logic        frameEnd_i = 1'b0;
    logic [23:0] fill_color = '0;
    logic [23:0] data_o;
    logic        dataValid_o;
    logic        busy_o;
    logic [11:0] linesIn_o;
    logic        overflow_o;

    int errors = 0;
    int checks = 0;

    // Stimulus, expected and observed per-cycle streams
    logic        st_v[$];
    logic [23:0] st_d[$];
    logic        st_fe[$];
    logic        ex_v[$];
    logic [23:0] ex_d[$];
    logic        ex_b[$];
    logic        ob_v[$];
    logic [23:0] ob_d[$];
    logic        ob_b[$];
    logic        ob_o[$];

    always #5 clk = ~clk;

    fill_vblank #(
        .H_DISP  (12'd8),
        .V_DISP  (12'd4),
        .LINE_GAP(12'd2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .dataValid_i(dataValid_i),
        .frameEnd_i (frameEnd_i),
`ifdef FILL_VBLANK_COLOR_EN
        .fillColor_i(fill_color),
`endif
        .data_o     (data_o),
        .dataValid_o(dataValid_o),
        .busy_o     (busy_o),
        .linesIn_o  (linesIn_o),
        .overflow_o (overflow_o)
    );

    // Colour the inserted lines are expected to carry
    function automatic logic [23:0] exp_color();
`ifdef FILL_VBLANK_COLOR_EN
        return fill_color;
`else
        return fill_color & 24'h000000;
`endif
    endfunction

    task automatic clear_q();
        st_v.delete(); st_d.delete(); st_fe.delete();
        ex_v.delete(); ex_d.delete(); ex_b.delete();
        ob_v.delete(); ob_d.delete(); ob_b.delete(); ob_o.delete();
    endtask

    task automatic push_cycle(input logic v, input logic [23:0] d, input logic fe,
                              input logic ev, input logic [23:0] ed, input logic eb);
        st_v.push_back(v); st_d.push_back(d); st_fe.push_back(fe);
        ex_v.push_back(ev); ex_d.push_back(ed); ex_b.push_back(eb);
    endtask

    // Reference model: a frame of nlines lines. Lines with index >= V are
    // cropped. If nlines < V, then V-nlines fill lines follow, with a gap of
    // G between consecutive fill lines and no gap after the last one.
    // busy is expected from the frameEnd cycle up to one cycle before the
    // last fill pixel shows on the output.
    task automatic build_frame(input int nlines, input bit fe_on_last,
                               input logic [23:0] color, output int fe_idx);
        int fill_lines, total, idx, idles;
        logic [23:0] px;
        bit fill;
        fill   = (nlines < V);
        fe_idx = -1;
        for (int k = 0; k < nlines; k++) begin
            for (int p = 0; p < H; p++) begin
                px = 24'($urandom);
                if (fe_on_last && k == nlines - 1 && p == H - 1) begin
                    fe_idx = st_v.size();
                    push_cycle(1'b1, px, 1'b1, k < V, (k < V) ? px : 24'h0, fill);
                end else begin
                    push_cycle(1'b1, px, 1'b0, k < V, (k < V) ? px : 24'h0, 1'b0);
                end
            end
            if (!(fe_on_last && k == nlines - 1)) begin
                idles = $urandom_range(1, 3);
                for (int i = 0; i < idles; i++) push_cycle(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0);
            end
        end
        if (fe_idx < 0) begin
            fe_idx = st_v.size();
            push_cycle(1'b0, 24'h0, 1'b1, 1'b0, 24'h0, fill);
        end
        if (fill) begin
            fill_lines = V - nlines;
            total = fill_lines * H + (fill_lines - 1) * G;
            idx = 0;
            for (int l = 0; l < fill_lines; l++) begin
                for (int p = 0; p < H; p++) begin
                    push_cycle(1'b0, 24'h0, 1'b0, 1'b1, color, idx != total - 1);
                    idx++;
                end
                if (l != fill_lines - 1) begin
                    for (int g = 0; g < G; g++) begin
                        push_cycle(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b1);
                        idx++;
                    end
                end
            end
            push_cycle(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0);
        end
        push_cycle(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0);
        push_cycle(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0);
    endtask

    // Drives the stimulus stream and captures the outputs #1 after each edge
    task automatic run_stim();
        for (int i = 0; i < st_v.size(); i++) begin
            data_i      = st_d[i];
            dataValid_i = st_v[i];
            frameEnd_i  = st_fe[i];
            @(posedge clk);
            #1;
            ob_v.push_back(dataValid_o);
            ob_d.push_back(data_o);
            ob_b.push_back(busy_o);
            ob_o.push_back(overflow_o);
        end
        data_i = '0; dataValid_i = 1'b0; frameEnd_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i = 24'($urandom); dataValid_i = 1'($urandom); frameEnd_i = 1'($urandom);
            @(posedge clk);
        end
        #1;
        checks++; if (data_o !== 24'h0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=000000", data_o); end
        checks++; if (dataValid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", dataValid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (linesIn_o !== 12'd0) begin errors++; $display("[TB] FAIL reset_linesIn got=%0d exp=0", linesIn_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow_o); end
        data_i = '0; dataValid_i = 1'b0; frameEnd_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One frame with nlines lines, compared cycle by cycle plus the summary outputs
    task automatic test_frame(input string name, input int nlines, input bit fe_on_last,
                              input logic [23:0] color);
        int fe_idx, busy_cnt;
        clear_q();
        fill_color = color;
        build_frame(nlines, fe_on_last, exp_color(), fe_idx);
        run_stim();
        busy_cnt = 0;
        for (int i = 0; i < ex_v.size(); i++) begin
            busy_cnt += int'(ob_b[i]);
            checks++;
            if (ob_v[i] !== ex_v[i] || ob_d[i] !== ex_d[i] || ob_b[i] !== ex_b[i]) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got v=%b d=%h busy=%b, exp v=%b d=%h busy=%b",
                         name, i, ob_v[i], ob_d[i], ob_b[i], ex_v[i], ex_d[i], ex_b[i]);
            end
        end
        checks++;
        if (busy_cnt !== ((nlines < V) ? ((V - nlines) * H + (V - nlines - 1) * G) : 0)) begin
            errors++; $display("[TB] FAIL %s busy_cycles got=%0d", name, busy_cnt);
        end
        checks++;
        if (linesIn_o !== 12'(nlines)) begin
            errors++; $display("[TB] FAIL %s linesIn got=%0d exp=%0d", name, linesIn_o, nlines);
        end
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++; $display("[TB] FAIL %s overflow got=%b exp=0", name, overflow_o);
        end
    endtask

    // Pixel pulse during fill, then a reset in the middle of a later fill
    task automatic test_overflow_and_reset();
        int fe_idx;
        clear_q();
        fill_color = 24'($urandom);
        build_frame(2, 1'b0, exp_color(), fe_idx);
        st_v[fe_idx + 3] = 1'b1;
        st_d[fe_idx + 3] = 24'($urandom);
        run_stim();
        for (int i = 0; i < ex_v.size(); i++) begin
            checks++;
            if (ob_v[i] !== ex_v[i] || ob_d[i] !== ex_d[i] || ob_b[i] !== ex_b[i]) begin
                errors++;
                $display("[TB] FAIL overflow_stream cycle %0d: got v=%b d=%h busy=%b, exp v=%b d=%h busy=%b",
                         i, ob_v[i], ob_d[i], ob_b[i], ex_v[i], ex_d[i], ex_b[i]);
            end
        end
        checks++; if (ob_o[fe_idx + 2] !== 1'b0) begin errors++; $display("[TB] FAIL overflow_early got=%b exp=0", ob_o[fe_idx + 2]); end
        checks++; if (ob_o[fe_idx + 3] !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set got=%b exp=1", ob_o[fe_idx + 3]); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky got=%b exp=1", overflow_o); end

        // Start a three-line fill and cut it short with reset
        clear_q();
        build_frame(1, 1'b1, exp_color(), fe_idx);
        while (st_v.size() > fe_idx + 5) begin
            void'(st_v.pop_back()); void'(st_d.pop_back()); void'(st_fe.pop_back());
        end
        run_stim();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL midfill_busy got=%b exp=1", busy_o); end
        rst_n = 1'b0;
        dataValid_i = 1'b1; data_i = 24'($urandom);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dataValid_i = 1'b0; data_i = '0;
        checks++;
        if (data_o !== 24'h0 || dataValid_o !== 1'b0 || busy_o !== 1'b0 || linesIn_o !== 12'd0 || overflow_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midfill_reset got d=%h v=%b busy=%b lines=%0d ovf=%b exp all 0",
                     data_o, dataValid_o, busy_o, linesIn_o, overflow_o);
        end
        // The block must be back in pass-through with clean counters
        test_frame("after_reset", V, 1'b0, 24'h0);
    endtask

    task automatic test_random();
        int nl;
        bit fl;
        for (int f = 0; f < 12; f++) begin
            nl = $urandom_range(0, 6);
            fl = (nl > 0) ? 1'($urandom) : 1'b0;
            test_frame($sformatf("random_frame%0d", f), nl, fl, 24'($urandom));
        end
    endtask

    initial begin
        $display("[TB] fill_vblank bench start");
        test_reset();
        test_frame("exact_frame", 4, 1'b0, 24'h0);
        test_frame("short_frame", 2, 1'b0, 24'h0);
        test_frame("crop_frame", 6, 1'b0, 24'h0);
        test_frame("fe_on_pixel", 3, 1'b1, 24'h0);
        test_frame("fill_color", 3, 1'b0, 24'hFF0000);
        test_overflow_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
